// File: rtl/eth_helper_pkg.sv
// Shared types and the round-robin helper for the stream arbiter.
// The helper searches upward from the previous winner and wraps at n, not at a power of two.
package eth_helper_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int unsigned MAX_SRC = 32;

    // Returns the first set request bit strictly after 'last', wrapping at n; 'last' if none is set.
    function automatic int unsigned rr_next(input logic [MAX_SRC-1:0] req,
                                            input int unsigned        last,
                                            input int unsigned        n);
        int unsigned idx;
        int unsigned result;
        logic        found;
        result = last;
        found  = 1'b0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (k <= n && !found && req[idx[4:0]]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is read straight from the array.
// Pushes into a full FIFO and pops from an empty one are ignored.
module stream_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned (no latch).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is reset deliberately so the head fields read zero while in reset; the array is tiny.
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin arbiter over the AXI channel taps: grants one source per burst, tags each beat
// with its source index and buffers it ahead of a single AXI-Stream master.
module stream_arbiter
    import eth_helper_pkg::*;
#(
    parameter  int NUM_SRC    = 5,
    parameter  int DATA_WIDTH = 128,
    parameter  int FIFO_DEPTH = 4,
    localparam int SRC_IDX_W  = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_in_progress,
    input  logic [NUM_SRC-1:0]            src_last,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [SRC_IDX_W-1:0]          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = DATA_WIDTH + 1 + SRC_IDX_W;

    arb_state_t           state_q, state_d;
    logic [SRC_IDX_W-1:0] grant_q, grant_d;
    logic [SRC_IDX_W-1:0] last_grant_q, last_grant_d;
    logic                 pushed_q, pushed_d;

    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full, fifo_empty;
    logic                 ready_ok, do_push, do_pop;
    logic [ENTRY_W-1:0]   push_entry, head_entry;

    // Ready depends only on registered state, so there is no path from src_valid to src_ready.
    assign ready_ok   = (state_q == GRANT) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign src_ready  = ready_ok ? (NUM_SRC'(1) << grant_q) : '0;
    assign do_push    = ready_ok && !fifo_full && src_valid[grant_q];
    assign push_entry = {src_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH], src_last[grant_q], grant_q};

    assign m_axis_tvalid = !fifo_empty;
    assign do_pop        = m_axis_tvalid && m_axis_tready;
    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = head_entry;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pushed_d     = pushed_q;
        case (state_q)
            IDLE: begin
                if (|src_valid && !(|src_in_progress)) begin
                    state_d  = GRANT;
                    grant_d  = SRC_IDX_W'(rr_next(MAX_SRC'(src_valid), 32'(last_grant_q), NUM_SRC));
                    pushed_d = 1'b0;
                end
            end
            GRANT: begin
                if (do_push) pushed_d = 1'b1;
                // Release on the last beat, or abandon a grant the source never used.
                if ((do_push && src_last[grant_q]) || (!pushed_q && !src_valid[grant_q])) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_IDX_W'(NUM_SRC - 1);
            pushed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pushed_q     <= pushed_d;
        end
    end

    stream_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (do_push),
        .wdata  (push_entry),
        .pop    (do_pop),
        .rdata  (head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: directed bursts push expected beats in the order the
// arbiter must serve them; a negedge monitor pops and compares every accepted output beat.
module tb_stream_arbiter;

    localparam int NS  = 5;
    localparam int DW  = 128;
    localparam int IW  = $clog2(NS);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] user;
        logic          last;
    } exp_t;

    logic                clk;
    logic                resetn;
    logic [NS-1:0]       src_valid;
    logic [NS-1:0]       src_in_progress;
    logic [NS-1:0]       src_last;
    logic [NS*DW-1:0]    src_data;
    logic [NS-1:0]       src_ready;
    logic [DW-1:0]       m_axis_tdata;
    logic [IW-1:0]       m_axis_tuser;
    logic                m_axis_tlast;
    logic                m_axis_tvalid;
    logic                m_axis_tready;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t src_q [NS][$];
    exp_t  exp_q [$];
    bit    drv_en;
    bit    acc [NS];

    stream_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .src_valid       (src_valid),
        .src_in_progress (src_in_progress),
        .src_last        (src_last),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] v);
        return {v, ~v, v ^ 32'h5A5A_5A5A, v};
    endfunction

    task automatic add_src(input int s, input logic [31:0] v, input logic last);
        beat_t b;
        b.data = pat(v);
        b.last = last;
        src_q[s].push_back(b);
    endtask

    task automatic add_exp(input int s, input logic [31:0] v, input logic last);
        exp_t e;
        e.data = pat(v);
        e.user = IW'(s);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit sources_busy();
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && (exp_q.size() != 0 || sources_busy()); k++) cyc(1);
        cyc(2);
        check(name, DW'(exp_q.size()), DW'(0));
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc(1);
    endtask

    // Source driver: presents the head of each source queue, retires it once accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (drv_en) begin
                for (int i = 0; i < NS; i++) begin
                    if (acc[i] && src_q[i].size() != 0) src_q[i].delete(0);
                    if (src_q[i].size() != 0) begin
                        src_valid[i]           = 1'b1;
                        src_data[i*DW +: DW]   = src_q[i][0].data;
                        src_last[i]            = src_q[i][0].last;
                    end else begin
                        src_valid[i]           = 1'b0;
                        src_data[i*DW +: DW]   = '0;
                        src_last[i]            = 1'b0;
                    end
                    acc[i] = src_valid[i] && src_ready[i];
                end
            end else begin
                for (int i = 0; i < NS; i++) acc[i] = 1'b0;
            end
        end
    end

    // Output monitor: every accepted beat must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", DW'(exp_q.size()), DW'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("out_tdata", m_axis_tdata, e.data);
                    check("out_tuser", DW'(m_axis_tuser), DW'(e.user));
                    check("out_tlast", DW'(m_axis_tlast), DW'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        resetn          = 1'b0;
        m_axis_tready   = 1'b0;
        drv_en          = 1'b1;
        src_valid       = '0;
        src_in_progress = '0;
        src_last        = '0;
        src_data        = '0;

        // Reset state
        cyc(2);
        check("rst_src_ready", DW'(src_ready), DW'(0));
        check("rst_tvalid",    DW'(m_axis_tvalid), DW'(0));
        check("rst_tdata",     m_axis_tdata, DW'(0));
        check("rst_tuser",     DW'(m_axis_tuser), DW'(0));
        check("rst_tlast",     DW'(m_axis_tlast), DW'(0));
        resetn = 1'b1;
        cyc(1);
        check("idle_src_ready", DW'(src_ready), DW'(0));

        // 1: single 3-beat burst from source 2, latency N -> N+1 ready -> N+2 tvalid
        m_axis_tready = 1'b1;
        add_src(2, 32'hA, 1'b0); add_src(2, 32'hB, 1'b0); add_src(2, 32'hC, 1'b1);
        add_exp(2, 32'hA, 1'b0); add_exp(2, 32'hB, 1'b0); add_exp(2, 32'hC, 1'b1);
        cyc(1);
        check("t1_ready_n1",  DW'(src_ready), DW'(5'b00100));
        check("t1_tvalid_n1", DW'(m_axis_tvalid), DW'(0));
        cyc(1);
        check("t1_tvalid_n2", DW'(m_axis_tvalid), DW'(1));
        wait_drain("t1_drain");
        check("t1_ready_idle", DW'(src_ready), DW'(0));

        // 2: round robin from reset, sources 0,1,3 with source 0 requesting twice
        apply_reset();
        add_src(0, 32'h100, 1'b1); add_src(0, 32'h101, 1'b1);
        add_src(1, 32'h110, 1'b1);
        add_src(3, 32'h130, 1'b1);
        add_exp(0, 32'h100, 1'b1); add_exp(1, 32'h110, 1'b1);
        add_exp(3, 32'h130, 1'b1); add_exp(0, 32'h101, 1'b1);
        wait_drain("t2_drain");

        // 3: backpressure on a 6-beat burst with a 4-deep buffer
        m_axis_tready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            add_src(1, 32'h200 + 32'(b), (b == 5));
            add_exp(1, 32'h200 + 32'(b), (b == 5));
        end
        cyc(10);
        check("t3_ready_full", DW'(src_ready), DW'(0));
        check("t3_accepted",   DW'(src_q[1].size()), DW'(2));
        check("t3_tvalid",     DW'(m_axis_tvalid), DW'(1));
        check("t3_head",       m_axis_tdata, pat(32'h200));
        cyc(2);
        check("t3_head_hold",  m_axis_tdata, pat(32'h200));
        m_axis_tready = 1'b1;
        wait_drain("t3_drain");

        // 4: another source mid-burst blocks new grants
        src_in_progress = 5'b00010;
        add_src(0, 32'h300, 1'b1);
        add_exp(0, 32'h300, 1'b1);
        cyc(5);
        check("t4_locked_ready",  DW'(src_ready), DW'(0));
        check("t4_locked_tvalid", DW'(m_axis_tvalid), DW'(0));
        src_in_progress = '0;
        cyc(1);
        check("t4_grant0", DW'(src_ready), DW'(5'b00001));
        wait_drain("t4_drain");

        // 5: source 4 abandons its grant before pushing; source 2 is served next
        drv_en = 1'b0;
        src_valid[4] = 1'b1; src_data[4*DW +: DW] = pat(32'h400); src_last[4] = 1'b1;
        cyc(1);
        check("t5_grant4", DW'(src_ready), DW'(5'b10000));
        src_valid[4] = 1'b0; src_last[4] = 1'b0; src_data[4*DW +: DW] = '0;
        src_valid[2] = 1'b1; src_data[2*DW +: DW] = pat(32'h402); src_last[2] = 1'b1;
        add_exp(2, 32'h402, 1'b1);
        cyc(1);
        check("t5_abandon", DW'(src_ready), DW'(0));
        cyc(1);
        check("t5_grant2", DW'(src_ready), DW'(5'b00100));
        cyc(1);
        src_valid = '0; src_last = '0; src_data = '0;
        check("t5_tvalid", DW'(m_axis_tvalid), DW'(1));
        wait_drain("t5_drain");

        // 6: asynchronous reset with three beats buffered
        m_axis_tready = 1'b0;
        src_valid[3] = 1'b1; src_data[3*DW +: DW] = pat(32'h600);
        cyc(1);
        check("t6_grant3", DW'(src_ready), DW'(5'b01000));
        cyc(1);
        src_data[3*DW +: DW] = pat(32'h601);
        cyc(1);
        src_data[3*DW +: DW] = pat(32'h602);
        cyc(1);
        src_valid = '0; src_data = '0;
        check("t6_buffered_tvalid", DW'(m_axis_tvalid), DW'(1));
        check("t6_buffered_head",   m_axis_tdata, pat(32'h600));
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("t6_rst_ready",  DW'(src_ready), DW'(0));
        check("t6_rst_tdata",  m_axis_tdata, DW'(0));
        check("t6_rst_tuser",  DW'(m_axis_tuser), DW'(0));
        check("t6_rst_tlast",  DW'(m_axis_tlast), DW'(0));
        cyc(2);
        resetn = 1'b1;
        cyc(1);
        drv_en = 1'b1;
        m_axis_tready = 1'b1;
        add_src(2, 32'h702, 1'b1);
        add_src(0, 32'h700, 1'b1);
        add_exp(0, 32'h700, 1'b1);
        add_exp(2, 32'h702, 1'b1);
        cyc(1);
        check("t6_fresh_grant0", DW'(src_ready), DW'(5'b00001));
        wait_drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
